// File: rtl/alu_serial_exec.sv
// ---------------------------------------------------------------------------
// alu_serial_exec
// Multi-cycle ALU execution unit. It takes the 3-bit ALUControl code and two
// DATA_WIDTH operands and works on SLICE_WIDTH bits per clock, LSB slice
// first. A valid/ready handshake on each side absorbs stalls both upstream
// and downstream.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   en         clock enable; when low, all state is frozen and in_ready=0
//   in_valid   opcode/operands valid          in_ready  unit can accept
//   ALUControl 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, others illegal
//   src_a      operand A                      src_b     operand B
//   out_valid  result valid                   out_ready consumer accepts
//   result     operation result               zero      result == 0
//   illegal    opcode was 101..111
// ---------------------------------------------------------------------------
module alu_serial_exec #(
    parameter int DATA_WIDTH  = 32,
    parameter int SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            ALUControl,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  illegal
);

    // DATA_WIDTH must be a multiple of SLICE_WIDTH, and wider than one slice.
    localparam int NSLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int KW      = $clog2(NSLICES + 1);
    localparam logic [KW-1:0] K_LAST = KW'(NSLICES);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                  state, state_nxt;
    logic [DATA_WIDTH-1:0]   a_sh, b_sh;      // operands, consumed LSB slice first
    logic [DATA_WIDTH-1:0]   acc;             // assembled slices
    logic [2:0]              op_q;
    logic                    a_msb, b_msb;    // operand signs kept for SLT
    logic                    carry;
    logic [KW-1:0]           k;

    logic                    op_illegal;
    logic [SLICE_WIDTH-1:0]  a_k, b_k, b_eff, slice_res;
    logic [SLICE_WIDTH:0]    slice_sum;
    logic                    lt;
    logic [DATA_WIDTH-1:0]   final_res;

    assign op_illegal = (ALUControl > OP_SLT);
    assign in_ready   = en && (state == IDLE);
    assign out_valid  = (state == DONE);

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else if (en)
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = op_illegal ? DONE : EXEC;
            EXEC: if (k == K_LAST) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One slice of arithmetic/logic per cycle
    always_comb begin
        a_k       = a_sh[SLICE_WIDTH-1:0];
        b_k       = b_sh[SLICE_WIDTH-1:0];
        b_eff     = (op_q == OP_SUB || op_q == OP_SLT) ? ~b_k : b_k;
        slice_sum = {1'b0, a_k} + {1'b0, b_eff} + {{SLICE_WIDTH{1'b0}}, carry};
        case (op_q)
            OP_AND:  slice_res = a_k & b_k;
            OP_OR:   slice_res = a_k | b_k;
            default: slice_res = slice_sum[SLICE_WIDTH-1:0];
        endcase
    end

    // Signed less-than: differing signs decide directly, otherwise the sign
    // of the wrapped difference does.
    always_comb begin
        lt        = (a_msb != b_msb) ? a_msb : acc[DATA_WIDTH-1];
        final_res = (op_q == OP_SLT) ? {{(DATA_WIDTH-1){1'b0}}, lt} : acc;
    end

    // Datapath. The extra EXEC cycle with k == K_LAST resolves SLT and
    // publishes the result; result/zero/illegal change only on DONE entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_sh    <= '0;
            b_sh    <= '0;
            acc     <= '0;
            op_q    <= OP_ADD;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            carry   <= 1'b0;
            k       <= '0;
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh  <= src_a;
                        b_sh  <= src_b;
                        a_msb <= src_a[DATA_WIDTH-1];
                        b_msb <= src_b[DATA_WIDTH-1];
                        op_q  <= ALUControl;
                        acc   <= '0;
                        k     <= '0;
                        carry <= (ALUControl == OP_SUB) || (ALUControl == OP_SLT);
                        if (op_illegal) begin
                            result  <= '0;
                            zero    <= 1'b1;
                            illegal <= 1'b1;
                        end
                    end
                end
                EXEC: begin
                    if (k != K_LAST) begin
                        acc   <= {slice_res, acc[DATA_WIDTH-1:SLICE_WIDTH]};
                        a_sh  <= a_sh >> SLICE_WIDTH;
                        b_sh  <= b_sh >> SLICE_WIDTH;
                        carry <= slice_sum[SLICE_WIDTH];
                        k     <= k + 1'b1;
                    end else begin
                        result  <= final_res;
                        zero    <= (final_res == '0);
                        illegal <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
module tb_alu_serial_exec;

    logic        clk = 1'b0;
    logic        rstn, en, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  ALUControl;
    logic [31:0] src_a, src_b, result;
    logic        zero, illegal;

    int n_checks = 0;
    int n_fail   = 0;

    alu_serial_exec #(.DATA_WIDTH(32), .SLICE_WIDTH(8)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .ALUControl(ALUControl),
        .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, count edges after the accept edge until out_valid,
    // check outputs, then let the consumer take it if out_ready is high.
    // drop_at > 0 lowers en for 3 cycles once that many edges have passed.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_zero,
                          input logic exp_ill, input int exp_lat, input int drop_at);
        int lat;
        check_eq({tag, " in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; ALUControl = op; src_a = a; src_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            if (lat == drop_at) begin
                en = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check_eq({tag, " in_ready en low"}, 64'(in_ready), 64'd0);
                en = 1'b1;
            end
        end
        check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, " result"}, 64'(result), 64'(exp_res));
        check_eq({tag, " zero"}, 64'(zero), 64'(exp_zero));
        check_eq({tag, " illegal"}, 64'(illegal), 64'(exp_ill));
        if (out_ready) begin
            @(posedge clk); #1;
            check_eq({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int spurious;
        rstn = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        ALUControl = 3'b000; src_a = '0; src_b = '0;
        #12;
        check_eq("reset out_valid", 64'(out_valid), 64'd0);
        check_eq("reset in_ready", 64'(in_ready), 64'd1);
        check_eq("reset result", 64'(result), 64'd0);
        check_eq("reset zero", 64'(zero), 64'd0);
        check_eq("reset illegal", 64'(illegal), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;

        run_op("add",      3'b000, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0, 1'b0, 5, 0);
        run_op("add wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 5, 0);
        run_op("sub eq",   3'b001, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b0, 5, 0);
        run_op("sub brw",  3'b001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 5, 0);
        run_op("slt neg",  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 5, 0);
        run_op("slt swap", 3'b100, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 5, 0);
        run_op("slt min",  3'b100, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 5, 0);
        run_op("illegal",  3'b110, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0000_0000, 1'b1, 1'b1, 0, 0);
        run_op("and",      3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 5, 0);
        run_op("or",       3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, 5, 0);

        // Backpressure: result held while the consumer stalls
        out_ready = 1'b0;
        run_op("bp", 3'b000, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 5, 0);
        repeat (10) begin
            @(posedge clk); #1;
            check_eq("bp hold valid", 64'(out_valid), 64'd1);
            check_eq("bp hold result", 64'(result), 64'h2345_6789);
            check_eq("bp in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp release valid", 64'(out_valid), 64'd0);
        check_eq("bp release in_ready", 64'(in_ready), 64'd1);

        // en low for 3 cycles mid-EXEC stretches latency by 3
        run_op("en drop", 3'b000, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0, 1'b0, 8, 2);

        // Reset during slice 2 of an ADD
        in_valid = 1'b1; ALUControl = 3'b000; src_a = 32'h0101_0101; src_b = 32'h0202_0202;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rstn = 1'b0;
        #1;
        check_eq("rst mid out_valid", 64'(out_valid), 64'd0);
        check_eq("rst mid in_ready", 64'(in_ready), 64'd1);
        check_eq("rst mid result", 64'(result), 64'd0);
        check_eq("rst mid zero", 64'(zero), 64'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        spurious = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        check_eq("rst no spurious valid", 64'(spurious), 64'd0);
        run_op("post rst", 3'b001, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
